// File: rtl/adder4_if.sv
// rtl/adder4_if.sv - operand/result bundle for the registered ripple-carry adder
//
// Signals:
//   A, B  [WIDTH-1:0]  unsigned operands (master -> slave)
//   cin                carry into bit 0   (master -> slave)
//   S     [WIDTH-1:0]  registered sum     (slave -> master)
//   cout               registered carry out of the MSB (slave -> master)
// Modports:
//   master  drives operands, observes the result
//   slave   the adder itself
interface adder4_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             cin;
  logic [WIDTH-1:0] S;
  logic             cout;

  modport master (
    output A,
    output B,
    output cin,
    input  S,
    input  cout
  );

  modport slave (
    input  A,
    input  B,
    input  cin,
    output S,
    output cout
  );
endinterface

// File: rtl/adder4.sv
// rtl/adder4.sv - registered WIDTH-bit structural ripple-carry adder
//
// full_adder ports:
//   a, b, ci  operand bits and carry in
//   s, co     sum bit and carry out
//
// adder4 ports:
//   clk   rising-edge clock
//   rst   synchronous reset, active-high; clears S and cout
//   bus   adder4_if.slave: A, B, cin in; S, cout out (both straight from flops)

module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);
endmodule

module adder4 #(
  parameter int WIDTH = 4
) (
  input  logic    clk,
  input  logic    rst,
  adder4_if.slave bus
);
  // carry[i] feeds cell i; carry[WIDTH] is the carry out of the MSB.
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_c;

  logic [WIDTH-1:0] s_d, s_q;
  logic             cout_d, cout_q;

  assign carry[0] = bus.cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    full_adder u_fa (
      .a  (bus.A[i]),
      .b  (bus.B[i]),
      .ci (carry[i]),
      .s  (sum_c[i]),
      .co (carry[i+1])
    );
  end

  always_comb begin
    s_d    = sum_c;
    cout_d = carry[WIDTH];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_q    <= '0;
      cout_q <= 1'b0;
    end else begin
      s_q    <= s_d;
      cout_q <= cout_d;
    end
  end

  // Outputs come only from the registers: no input-to-output combinational path.
  assign bus.S    = s_q;
  assign bus.cout = cout_q;
endmodule

// File: tb/tb_adder4.sv
// tb/tb_adder4.sv - directed and exhaustive bench for adder4
module tb_adder4;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  adder4_if #(.WIDTH(4)) bus ();

  adder4 #(.WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got {cout,S}=%b required %b", tag, got, exp);
    end
  endtask

  // Drive one operand set, take one edge, then settle just past it.
  task automatic apply(input logic r, input logic [3:0] a, input logic [3:0] b, input logic c);
    rst     = r;
    bus.A   = a;
    bus.B   = b;
    bus.cin = c;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       c;
    logic [4:0] exp;
    string      tag;
  } vec_t;

  vec_t vecs [7];
  logic [4:0] held;
  logic [4:0] exp_sum;

  initial begin
    vecs[0] = '{4'b0000, 4'b0000, 1'b0, 5'b0_0000, "zero"};
    vecs[1] = '{4'b0101, 4'b0011, 1'b0, 5'b0_1000, "5+3"};
    vecs[2] = '{4'b1010, 4'b0101, 1'b0, 5'b0_1111, "10+5"};
    vecs[3] = '{4'b1111, 4'b0001, 1'b1, 5'b1_0001, "15+1+1"};
    vecs[4] = '{4'b1001, 4'b1100, 1'b1, 5'b1_0110, "9+12+1"};
    vecs[5] = '{4'b1111, 4'b1111, 1'b1, 5'b1_1111, "max"};
    vecs[6] = '{4'b1111, 4'b0000, 1'b1, 5'b1_0000, "15+0+1"};

    // Reset held for two edges with all-ones operands.
    apply(1'b1, 4'hF, 4'hF, 1'b1);
    check("reset_edge1", {bus.cout, bus.S}, 5'b0_0000);
    apply(1'b1, 4'hF, 4'hF, 1'b1);
    check("reset_edge2", {bus.cout, bus.S}, 5'b0_0000);
    apply(1'b0, 4'hF, 4'hF, 1'b1);
    check("first_after_reset", {bus.cout, bus.S}, 5'b1_1111);

    // Back-to-back vectors, with inputs toggled mid-cycle to confirm outputs hold.
    for (int i = 0; i < 7; i++) begin
      apply(1'b0, vecs[i].a, vecs[i].b, vecs[i].c);
      check(vecs[i].tag, {bus.cout, bus.S}, vecs[i].exp);
      held    = {bus.cout, bus.S};
      #2;
      bus.A   = ~vecs[i].a;
      bus.B   = ~vecs[i].b;
      bus.cin = ~vecs[i].c;
      #1;
      check({vecs[i].tag, "_hold"}, {bus.cout, bus.S}, vecs[i].exp);
      if (held !== vecs[i].exp) begin
        // already reported by the check above
      end
    end

    // Exhaustive sweep with one reset edge in the middle.
    for (int i = 0; i < 512; i++) begin
      logic [3:0] a;
      logic [3:0] b;
      logic       c;
      logic       r;
      a = i[3:0];
      b = i[7:4];
      c = i[8];
      r = (i == 200);
      apply(r, a, b, c);
      exp_sum = r ? 5'd0 : ({1'b0, a} + {1'b0, b} + {4'd0, c});
      if (r)
        check("mid_reset", {bus.cout, bus.S}, exp_sum);
      else if (i == 201)
        check("after_mid_reset", {bus.cout, bus.S}, exp_sum);
      else
        check("exhaustive", {bus.cout, bus.S}, exp_sum);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
